// File: rtl/seg7_scan_mux_pkg.sv
// Shared types and helpers for the 7-segment scan driver.
// Sized for the widest supported display (8 digits); callers truncate.
package seg7_pkg;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_t;

  localparam logic [7:0] AN_OFF = 8'hFF;

  // Bit i set when digit i is a leading zero; digit 0 always stays visible.
  function automatic logic [7:0] lz_mask(input logic [31:0] value, input int n);
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        zero_above = zero_above & (value[4*i +: 4] == 4'h0);
        lz_mask[i] = (i > 0) && zero_above;
      end
    end
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display-word input and scan outputs of seg7_scan_mux.
interface seg7_scan_mux_if #(parameter int NUM_DIGITS = 4);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_mask;
  logic [3:0]              hex;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [IW-1:0]           digit_idx;
  logic                    frame_start;

  modport master (output value, load, digit_mask,
                  input  hex, an_n, digit_idx, frame_start);
  modport slave  (input  value, load, digit_mask,
                  output hex, an_n, digit_idx, frame_start);
endinterface

// File: rtl/seg7_scan_mux_scan_timer.sv
// BLANK/SHOW sequencer: counts cycles in each state and walks the digit index.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  output scan_state_t                   o_state,
  output logic [$clog2(NUM_DIGITS)-1:0] o_idx,
  output logic [$clog2(NUM_DIGITS)-1:0] o_idx_nxt,
  output logic                          o_show_start,
  output logic                          o_slot_end,
  output logic                          o_frame_end
);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CW   = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;

  scan_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          w_blank_end, w_slot_end, w_last;

  assign w_blank_end = (r_state == BLANK) && (r_cnt == CW'(BLANK_CYCLES - 1));
  assign w_slot_end  = (r_state == SHOW)  && (r_cnt == CW'(REFRESH_CYCLES - 1));
  assign w_last      = (r_idx == IW'(NUM_DIGITS - 1));

  assign o_state      = r_state;
  assign o_idx        = r_idx;
  assign o_idx_nxt    = w_slot_end ? (w_last ? '0 : r_idx + 1'b1) : r_idx;
  assign o_show_start = w_blank_end;
  assign o_slot_end   = w_slot_end;
  assign o_frame_end  = w_slot_end && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_idx <= o_idx_nxt;
      if (w_blank_end) begin
        r_cnt   <= '0;
        r_state <= SHOW;
      end else if (w_slot_end) begin
        r_cnt   <= '0;
        r_state <= BLANK;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg7_scan_mux.sv
// Common-anode multi-digit scan driver: frame-atomic display word, blanking
// gaps between digits and optional leading-zero suppression.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int LZ_SUPPRESS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_mux_if.slave   bus
);
  localparam int IW = $clog2(NUM_DIGITS);

  scan_state_t             w_state;
  logic [IW-1:0]           w_idx, w_idx_nxt;
  logic                    w_show_start, w_slot_end, w_frame_end;
  logic                    w_show_nxt;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_lz, w_lit;

  logic [4*NUM_DIGITS-1:0] r_shadow, r_pending;
  logic                    r_pend_vld;
  logic [3:0]              r_hex;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic [IW-1:0]           r_digit_idx;
  logic                    r_frame_start;

  seg7_scan_timer #(
    .NUM_DIGITS     (NUM_DIGITS),
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .BLANK_CYCLES   (BLANK_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .o_state      (w_state),
    .o_idx        (w_idx),
    .o_idx_nxt    (w_idx_nxt),
    .o_show_start (w_show_start),
    .o_slot_end   (w_slot_end),
    .o_frame_end  (w_frame_end)
  );

  // Outputs are registered from the timer's next state so they change on the
  // same edge as the state itself.
  assign w_show_nxt = w_show_start | ((w_state == SHOW) && !w_slot_end);
  assign w_nib      = r_shadow[{w_idx_nxt, 2'b00} +: 4];
  assign w_lz       = (LZ_SUPPRESS != 0) ? NUM_DIGITS'(lz_mask(32'(r_shadow), NUM_DIGITS)) : '0;
  assign w_lit      = (NUM_DIGITS'(1) << w_idx_nxt) & bus.digit_mask & ~w_lz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow   <= '0;
      r_pending  <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_frame_end) begin
      // A load landing on the boundary bypasses pending and wins outright.
      if (bus.load)        r_shadow <= bus.value;
      else if (r_pend_vld) r_shadow <= r_pending;
      r_pend_vld <= 1'b0;
    end else if (bus.load) begin
      r_pending  <= bus.value;
      r_pend_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex         <= '0;
      r_an_n        <= AN_OFF[NUM_DIGITS-1:0];
      r_digit_idx   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_show_nxt) r_hex <= w_nib;
      r_an_n        <= w_show_nxt ? ~w_lit : AN_OFF[NUM_DIGITS-1:0];
      r_digit_idx   <= w_idx_nxt;
      r_frame_start <= w_show_start && (w_idx == '0);
    end
  end

  assign bus.hex         = r_hex;
  assign bus.an_n        = r_an_n;
  assign bus.digit_idx   = r_digit_idx;
  assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: 4 digits, 4-cycle refresh, 2-cycle blank.
module tb_seg7_scan_mux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_mux_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_mux #(
    .NUM_DIGITS(4), .REFRESH_CYCLES(4), .BLANK_CYCLES(2), .LZ_SUPPRESS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int t;
  int nvec;
  int nerr;
  logic [3:0] c_an  [24];
  logic [3:0] c_hex [24];
  logic [1:0] c_idx [24];
  logic       c_fs  [24];

  // t counts edges since reset release; t%24 == 0 is the frame boundary.
  task automatic step();
    @(posedge clk); #1; t++;
  endtask

  task automatic goto_phase(input int q);
    for (int k = 0; k < 24 && (t % 24) != q; k++) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value = v; bus.load = 1'b1; step(); bus.load = 1'b0;
  endtask

  task automatic capture();
    for (int s = 0; s < 24; s++) begin
      c_an[s] = bus.an_n; c_hex[s] = bus.hex; c_idx[s] = bus.digit_idx; c_fs[s] = bus.frame_start;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.digit_mask = 4'hF;
    step(); step(); step();
    rst = 1'b0; t = 0;
    nvec++;
    if ({bus.an_n, bus.hex, bus.digit_idx, bus.frame_start} !== {4'hF, 4'h0, 2'd0, 1'b0}) begin
      nerr++; $display("FAIL reset_vals got an=%b hex=%h idx=%0d fs=%b want an=1111 hex=0 idx=0 fs=0",
                       bus.an_n, bus.hex, bus.digit_idx, bus.frame_start);
    end
    step();
    nvec++;
    if (bus.an_n !== 4'hF) begin nerr++; $display("FAIL reset_blank got an=%b want 1111", bus.an_n); end
    step();
    nvec++;
    if ({bus.an_n, bus.hex, bus.frame_start} !== {4'b1110, 4'h0, 1'b1}) begin
      nerr++; $display("FAIL first_show got an=%b hex=%h fs=%b want an=1110 hex=0 fs=1", bus.an_n, bus.hex, bus.frame_start);
    end
    step();
    nvec++;
    if (bus.frame_start !== 1'b0) begin nerr++; $display("FAIL fs_pulse got %b want 0", bus.frame_start); end
  endtask

  task automatic test_basic();
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] eh [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] ph = 4'h0;
    do_load(16'h1234);
    goto_phase(0);
    capture();
    for (int s = 0; s < 24; s++) begin
      int j = s / 6, r = s % 6;
      logic [3:0] wa = (r < 2) ? 4'hF : ea[j];
      logic [3:0] wh = (r >= 2) ? eh[j] : ((j > 0) ? eh[j-1] : ph);
      nvec++;
      if ({c_an[s], c_hex[s], c_idx[s], c_fs[s]} !== {wa, wh, 2'(j), (s == 2)}) begin
        nerr++; $display("FAIL basic s=%0d got an=%b hex=%h idx=%0d fs=%b want an=%b hex=%h idx=%0d fs=%b",
                         s, c_an[s], c_hex[s], c_idx[s], c_fs[s], wa, wh, j, (s == 2));
      end
    end
  endtask

  task automatic test_lz();
    logic [3:0] ea [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    logic [15:0] vals [2] = '{16'h0005, 16'h0000};
    logic [3:0] phs [2] = '{4'h1, 4'h0};
    for (int f = 0; f < 2; f++) begin
      goto_phase(3);
      do_load(vals[f]);
      goto_phase(0);
      capture();
      for (int s = 0; s < 24; s++) begin
        int j = s / 6, r = s % 6;
        logic [15:0] v = vals[f];
        logic [3:0] wa = (r < 2) ? 4'hF : ea[j];
        logic [3:0] wh = (r >= 2) ? v[4*j +: 4] : ((j > 0) ? v[4*(j-1) +: 4] : phs[f]);
        nvec++;
        if ({c_an[s], c_hex[s], c_idx[s], c_fs[s]} !== {wa, wh, 2'(j), (s == 2)}) begin
          nerr++; $display("FAIL lz_%0d s=%0d got an=%b hex=%h idx=%0d fs=%b want an=%b hex=%h idx=%0d fs=%b",
                           f, s, c_an[s], c_hex[s], c_idx[s], c_fs[s], wa, wh, j, (s == 2));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] eh [4] = '{4'h6, 4'h7, 4'h8, 4'h9};
    logic [3:0] ph = 4'h0;
    goto_phase(5);
    do_load(16'hABCD);
    step();
    do_load(16'h9876);
    // Rest of the current frame must still reflect shadow 0x0000.
    for (int k = 0; k < 24 && (t % 24) != 0; k++) begin
      nvec++;
      if ({bus.an_n, bus.hex} !== {4'hF, 4'h0}) begin
        nerr++; $display("FAIL b2b_cur t=%0d got an=%b hex=%h want an=1111 hex=0", t, bus.an_n, bus.hex);
      end
      step();
    end
    capture();
    for (int s = 0; s < 24; s++) begin
      int j = s / 6, r = s % 6;
      logic [3:0] wa = (r < 2) ? 4'hF : ea[j];
      logic [3:0] wh = (r >= 2) ? eh[j] : ((j > 0) ? eh[j-1] : ph);
      nvec++;
      if ({c_an[s], c_hex[s], c_idx[s], c_fs[s]} !== {wa, wh, 2'(j), (s == 2)}) begin
        nerr++; $display("FAIL b2b_next s=%0d got an=%b hex=%h idx=%0d fs=%b want an=%b hex=%h idx=%0d fs=%b",
                         s, c_an[s], c_hex[s], c_idx[s], c_fs[s], wa, wh, j, (s == 2));
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [3:0] eh [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
    logic [3:0] phs [2] = '{4'h9, 4'h0};
    goto_phase(10);
    do_load(16'h1111);
    goto_phase(23);
    do_load(16'h00F0);
    // Second frame proves the stale pending 0x1111 was discarded.
    for (int f = 0; f < 2; f++) begin
      capture();
      for (int s = 0; s < 24; s++) begin
        int j = s / 6, r = s % 6;
        logic [3:0] wa = (r < 2) ? 4'hF : ea[j];
        logic [3:0] wh = (r >= 2) ? eh[j] : ((j > 0) ? eh[j-1] : phs[f]);
        nvec++;
        if ({c_an[s], c_hex[s], c_idx[s], c_fs[s]} !== {wa, wh, 2'(j), (s == 2)}) begin
          nerr++; $display("FAIL bnd_%0d s=%0d got an=%b hex=%h idx=%0d fs=%b want an=%b hex=%h idx=%0d fs=%b",
                           f, s, c_an[s], c_hex[s], c_idx[s], c_fs[s], wa, wh, j, (s == 2));
        end
      end
    end
  endtask

  task automatic test_mask();
    logic [3:0] ea [4] = '{4'b1111, 4'b1101, 4'b1111, 4'b0111};
    logic [3:0] phs [2] = '{4'h0, 4'h1};
    goto_phase(3);
    do_load(16'h1111);
    bus.digit_mask = 4'b1010;
    goto_phase(0);
    for (int f = 0; f < 2; f++) begin
      capture();
      for (int s = 0; s < 24; s++) begin
        int j = s / 6, r = s % 6;
        logic [3:0] wa = (r < 2) ? 4'hF : ea[j];
        logic [3:0] wh = (r < 2 && j == 0) ? phs[f] : 4'h1;
        nvec++;
        if ({c_an[s], c_hex[s], c_idx[s], c_fs[s]} !== {wa, wh, 2'(j), (s == 2)}) begin
          nerr++; $display("FAIL mask_%0d s=%0d got an=%b hex=%h idx=%0d fs=%b want an=%b hex=%h idx=%0d fs=%b",
                           f, s, c_an[s], c_hex[s], c_idx[s], c_fs[s], wa, wh, j, (s == 2));
        end
      end
    end
    bus.digit_mask = 4'hF;
  endtask

  task automatic test_reset_mid();
    goto_phase(5);
    do_load(16'h2222);
    goto_phase(14);
    nvec++;
    if ({bus.an_n, bus.hex, bus.digit_idx} !== {4'b1011, 4'h1, 2'd2}) begin
      nerr++; $display("FAIL rmid_pre got an=%b hex=%h idx=%0d want an=1011 hex=1 idx=2", bus.an_n, bus.hex, bus.digit_idx);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if ({bus.an_n, bus.hex, bus.digit_idx, bus.frame_start} !== {4'hF, 4'h0, 2'd0, 1'b0}) begin
      nerr++; $display("FAIL rmid_async got an=%b hex=%h idx=%0d fs=%b want an=1111 hex=0 idx=0 fs=0",
                       bus.an_n, bus.hex, bus.digit_idx, bus.frame_start);
    end
    step(); step();
    rst = 1'b0; t = 0;
    step();
    nvec++;
    if (bus.an_n !== 4'hF) begin nerr++; $display("FAIL rmid_blank got an=%b want 1111", bus.an_n); end
    step();
    nvec++;
    if ({bus.an_n, bus.hex, bus.digit_idx, bus.frame_start} !== {4'b1110, 4'h0, 2'd0, 1'b1}) begin
      nerr++; $display("FAIL rmid_show got an=%b hex=%h idx=%0d fs=%b want an=1110 hex=0 idx=0 fs=1",
                       bus.an_n, bus.hex, bus.digit_idx, bus.frame_start);
    end
    // Pending 0x2222 was lost, so the next frame still shows a lone "0".
    step();
    goto_phase(2);
    nvec++;
    if ({bus.an_n, bus.hex} !== {4'b1110, 4'h0}) begin
      nerr++; $display("FAIL rmid_lost0 got an=%b hex=%h want an=1110 hex=0", bus.an_n, bus.hex);
    end
    for (int k = 0; k < 6; k++) step();
    nvec++;
    if ({bus.an_n, bus.hex, bus.digit_idx} !== {4'hF, 4'h0, 2'd1}) begin
      nerr++; $display("FAIL rmid_lost1 got an=%b hex=%h idx=%0d want an=1111 hex=0 idx=1", bus.an_n, bus.hex, bus.digit_idx);
    end
  endtask

  initial begin
    t = 0; nvec = 0; nerr = 0;
    test_reset();
    test_basic();
    test_lz();
    test_back_to_back();
    test_boundary_load();
    test_mask();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
